// File: rtl/host_interface.sv
// host_interface
//   Host-side responder for the matrix-unit control handshake.
//   On a held host_req_mat it accepts N_ELEMS operand bytes from the external
//   stream and writes them to weight/input memory (addresses 0..N_ELEMS-1).
//   On N_RES host_mat_wb strobes it captures results into a local buffer and
//   then drains them byte-serially on out_data/out_valid/out_ready.
//
//   Optional build macro: HOST_IF_SAT8_EN
//     defined   : each result saturates to signed 8-bit at capture, one byte
//                 per result is sent.
//     undefined : two bytes per 16-bit result, LSB first, no saturation.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   host_req_mat          level request for an operand load
//   host_mat_wb, res_data result strobe and 16-bit signed result
//   in_data/in_valid/in_ready     external operand byte stream
//   mem_we/mem_addr/mem_wdata     registered memory write port
//   mat_loaded            pulse after the last operand write
//   out_data/out_valid/out_ready  external result byte stream
//   done                  pulse after the last result byte is taken
//   err                   sticky flag: host_mat_wb seen outside WAIT
module host_interface #(
  parameter int DATA_W  = 8,
  parameter int N_ELEMS = 8,
  parameter int N_RES   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       host_req_mat,
  input  logic                       host_mat_wb,
  input  logic [15:0]                res_data,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       mem_we,
  output logic [$clog2(N_ELEMS)-1:0] mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       mat_loaded,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       done,
  output logic                       err
);

`ifdef HOST_IF_SAT8_EN
  localparam int BUF_W   = 8;
  localparam int N_BYTES = N_RES;
`else
  localparam int BUF_W   = 16;
  localparam int N_BYTES = 2 * N_RES;
`endif

  localparam int AW = $clog2(N_ELEMS);
  localparam int RW = $clog2(N_RES);
  localparam int BW = $clog2(N_BYTES);

  localparam logic [AW-1:0] LOAD_LAST = AW'(N_ELEMS - 1);
  localparam logic [RW-1:0] WB_LAST   = RW'(N_RES - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(N_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      load_cnt_q, load_cnt_d;
  logic [RW-1:0]      wb_cnt_q, wb_cnt_d;
  logic [BW-1:0]      byte_idx_q, byte_idx_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               mat_loaded_q, mat_loaded_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [BUF_W-1:0]   res_buf_q [N_RES];
  logic [BUF_W-1:0]   cap_val;
  logic [BW-1:0]      next_idx;
  logic [DATA_W-1:0]  next_byte;

`ifdef HOST_IF_SAT8_EN
  function automatic logic [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127)       return 8'h7F;
    else if (v < -16'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction
`endif

  always_comb begin
`ifdef HOST_IF_SAT8_EN
    cap_val   = sat8(res_data);
`else
    cap_val   = res_data;
`endif
    next_idx  = byte_idx_q + 1'b1;
`ifdef HOST_IF_SAT8_EN
    next_byte = res_buf_q[next_idx][DATA_W-1:0];
`else
    // odd byte index selects the upper half of result idx/2
    next_byte = next_idx[0] ? res_buf_q[next_idx[BW-1:1]][2*DATA_W-1:DATA_W]
                            : res_buf_q[next_idx[BW-1:1]][DATA_W-1:0];
`endif
  end

  // Result buffer carries no reset; its contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT && host_mat_wb) res_buf_q[wb_cnt_q] <= cap_val;
  end

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    byte_idx_d   = byte_idx_q;
    in_ready_d   = in_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mat_loaded_d = 1'b0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    done_d       = 1'b0;
    err_d        = err_q | (host_mat_wb && state_q != S_WAIT);

    unique case (state_q)
      S_IDLE: begin
        if (host_req_mat) begin
          state_d    = S_LOAD;
          in_ready_d = 1'b1;
        end
      end
      S_LOAD: begin
        // a dropped request aborts before any write in this cycle
        if (!host_req_mat) begin
          state_d    = S_IDLE;
          in_ready_d = 1'b0;
          load_cnt_d = '0;
        end else if (in_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = load_cnt_q;
          mem_wdata_d = in_data;
          if (load_cnt_q == LOAD_LAST) begin
            mat_loaded_d = 1'b1;
            load_cnt_d   = '0;
            in_ready_d   = 1'b0;
            state_d      = S_WAIT;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (host_mat_wb) begin
          if (wb_cnt_q == WB_LAST) begin
            wb_cnt_d    = '0;
            byte_idx_d  = '0;
            out_valid_d = 1'b1;
            out_data_d  = res_buf_q[0][DATA_W-1:0];
            state_d     = S_DRAIN;
          end else begin
            wb_cnt_d = wb_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (byte_idx_q == BYTE_LAST) begin
            byte_idx_d  = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            byte_idx_d = next_idx;
            out_data_d = next_byte;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      load_cnt_q   <= '0;
      wb_cnt_q     <= '0;
      byte_idx_q   <= '0;
      in_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mat_loaded_q <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      byte_idx_q   <= byte_idx_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mat_loaded_q <= mat_loaded_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mat_loaded = mat_loaded_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_host_interface.sv
// Directed self-checking bench for host_interface.
// Expected output bytes are hand-computed for both build variants.
module tb_host_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_req_mat = 1'b0;
  logic        host_mat_wb = 1'b0;
  logic [15:0] res_data = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, mem_we, mat_loaded, out_valid, done, err;
  logic [2:0]  mem_addr;
  logic [7:0]  mem_wdata, out_data;

  int errors = 0;
  int checks = 0;

  host_interface #(.DATA_W(8), .N_ELEMS(8), .N_RES(4)) dut (
    .clk(clk), .rst_n(rst_n), .host_req_mat(host_req_mat), .host_mat_wb(host_mat_wb),
    .res_data(res_data), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mat_loaded(mat_loaded),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [15:0] res_a [4] = '{16'h0123, 16'hFFFE, 16'h7FFF, 16'h8000};
  logic [15:0] res_b [4] = '{16'h0080, 16'hFF80, 16'h007F, 16'hFF7F};
`ifdef HOST_IF_SAT8_EN
  localparam int NB = 4;
  logic [7:0] exp_a [NB] = '{8'h7F, 8'hFE, 8'h7F, 8'h80};
  logic [7:0] exp_b [NB] = '{8'h7F, 8'h80, 8'h7F, 8'h80};
`else
  localparam int NB = 8;
  logic [7:0] exp_a [NB] = '{8'h23, 8'h01, 8'hFE, 8'hFF, 8'hFF, 8'h7F, 8'h00, 8'h80};
  logic [7:0] exp_b [NB] = '{8'h80, 8'h00, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'h7F, 8'hFF};
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   16'(in_ready),   16'h0);
    check({tag, "_mem_we"},     16'(mem_we),     16'h0);
    check({tag, "_mem_addr"},   16'(mem_addr),   16'h0);
    check({tag, "_mem_wdata"},  16'(mem_wdata),  16'h0);
    check({tag, "_mat_loaded"}, 16'(mat_loaded), 16'h0);
    check({tag, "_out_data"},   16'(out_data),   16'h0);
    check({tag, "_out_valid"},  16'(out_valid),  16'h0);
    check({tag, "_done"},       16'(done),       16'h0);
    check({tag, "_err"},        16'(err),        16'h0);
  endtask

  task automatic do_load(input bit gapped, input logic [7:0] base);
    int n = 0;
    host_req_mat = 1'b1;
    tick();
    check("load_in_ready_start", 16'(in_ready), 16'h1);
    for (int c = 0; c < 32 && n < 8; c++) begin
      in_valid = !gapped || (c % 2 == 0);
      in_data  = base + 8'(n);
      tick();
      if (in_valid) begin
        check("load_we",         16'(mem_we),     16'h1);
        check("load_addr",       16'(mem_addr),   16'(n));
        check("load_wdata",      16'(mem_wdata),  16'(base + 8'(n)));
        check("load_mat_loaded", 16'(mat_loaded), 16'(n == 7));
        check("load_in_ready",   16'(in_ready),   16'(n != 7));
        n++;
      end else begin
        check("gap_we", 16'(mem_we), 16'h0);
      end
    end
    in_valid     = 1'b0;
    host_req_mat = 1'b0;
    tick();
    check("mat_loaded_one_cycle", 16'(mat_loaded), 16'h0);
    check("no_extra_write",       16'(mem_we),     16'h0);
    check("wait_in_ready",        16'(in_ready),   16'h0);
  endtask

  task automatic do_wb(input bit use_b);
    for (int j = 0; j < 4; j++) begin
      host_mat_wb = 1'b1;
      res_data    = use_b ? res_b[j] : res_a[j];
      tick();
      check("wb_out_valid", 16'(out_valid), 16'(j == 3));
    end
    host_mat_wb = 1'b0;
    check("wb_first_byte", 16'(out_data), 16'(use_b ? exp_b[0] : exp_a[0]));
  endtask

  task automatic do_drain(input bit use_b, input bit stall);
    int k = 0;
    for (int c = 0; c < 40 && k < NB; c++) begin
      out_ready = !(stall && c >= 2 && c < 5);
      check("drain_valid",    16'(out_valid), 16'h1);
      check("drain_data",     16'(out_data),  16'(use_b ? exp_b[k] : exp_a[k]));
      check("drain_done_low", 16'(done),      16'h0);
      tick();
      if (out_ready) k++;
    end
    check("drain_done",      16'(done),      16'h1);
    check("drain_valid_end", 16'(out_valid), 16'h0);
    out_ready = 1'b0;
    tick();
    check("done_one_cycle", 16'(done),     16'h0);
    check("idle_in_ready",  16'(in_ready), 16'h0);
  endtask

  initial begin
    // reset state
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // contiguous load, writeback, free-running drain
    do_load(1'b0, 8'h01);
    do_wb(1'b0);
    do_drain(1'b0, 1'b0);
    check("err_clean", 16'(err), 16'h0);

    // abort after three bytes
    host_req_mat = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      tick();
      check("abort_addr", 16'(mem_addr), 16'(i));
    end
    in_valid     = 1'b0;
    host_req_mat = 1'b0;
    tick();
    check("abort_in_ready",   16'(in_ready),   16'h0);
    check("abort_mat_loaded", 16'(mat_loaded), 16'h0);
    check("abort_we",         16'(mem_we),     16'h0);
    tick();
    check("abort_mat_loaded_late", 16'(mat_loaded), 16'h0);

    // writeback strobe in IDLE sets sticky err
    host_mat_wb = 1'b1;
    res_data    = 16'h5555;
    tick();
    host_mat_wb = 1'b0;
    check("err_set",       16'(err),       16'h1);
    check("err_no_output", 16'(out_valid), 16'h0);

    // gapped load restarts at addr 0, boundary results, stalled drain
    do_load(1'b1, 8'h10);
    do_wb(1'b1);
    do_drain(1'b1, 1'b1);
    check("err_sticky", 16'(err), 16'h1);

    // reset in the middle of a drain
    do_load(1'b0, 8'h30);
    do_wb(1'b0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // normal operation after reset
    do_load(1'b0, 8'h40);
    do_wb(1'b1);
    do_drain(1'b1, 1'b0);
    check("err_after_reset", 16'(err), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_interface.md
# host_interface

Host-side responder for the matrix-unit control handshake. When the control unit raises `host_req_mat`, this block pulls eight operand bytes from the external byte stream and writes them into weight/input memory. When the control unit strobes `host_mat_wb`, it captures four results into a local buffer and serializes them back out on the external byte stream. It sits between the chip pins and the control unit / weight memory.

## Interface
Parameters:
- `DATA_W`, 8: operand byte width.
- `N_ELEMS`, 8: operands per load (4 weights + 4 inputs).
- `N_RES`, 4: results per writeback.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `host_req_mat`  in  1  level; the control unit requests an operand load.
- `host_mat_wb`  in  1  one-cycle strobe per result; `res_data` is valid with it.
- `res_data`  in  16  signed result.
- `in_data`  in  8  external operand byte.
- `in_valid`  in  1  external byte valid.
- `in_ready`  out  1  block accepts `in_data`.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  3  memory write address.
- `mem_wdata`  out  8  memory write data.
- `mat_loaded`  out  1  one-cycle pulse after the 8th operand write.
- `out_data`  out  8  result byte.
- `out_valid`  out  1  result byte valid.
- `out_ready`  in  1  external sink accepts `out_data`.
- `done`  out  1  one-cycle pulse after the last result byte is taken.
- `err`  out  1  sticky protocol-error flag.

## Operation
- States:
  - IDLE: all strobes are 0. `host_req_mat`=1 moves to LOAD.
  - LOAD: `in_ready`=1.
    - On each handshake (`in_valid && in_ready`), `mem_we`/`mem_addr`/`mem_wdata` are registered with addr=`load_cnt`, then `load_cnt`++.
    - When the handshake with `load_cnt`=7 occurs, pulse `mat_loaded`, clear `load_cnt`, go to WAIT.
    - If `host_req_mat` falls in LOAD: abort. Clear `load_cnt`, go to IDLE, issue no `mat_loaded`. Writes already made stand.
  - WAIT: `in_ready`=0.
    - Each `host_mat_wb` writes `res_data` into `buf[wb_cnt]`, then `wb_cnt`++.
    - When the capture with `wb_cnt`=3 occurs, clear `wb_cnt`, go to DRAIN.
  - DRAIN: `out_valid`=1 and `out_data`=current byte.
    - The byte index advances only on `out_valid && out_ready`.
    - `out_data` is held stable while stalled.
    - After the last byte is taken: pulse `done`, go to IDLE.
- Byte order: result 0 first; within a result, the LSB first (unless the macro below is set).
- `host_mat_wb` outside WAIT is ignored and sets `err`. `err` is cleared only by reset.
- `host_req_mat` outside IDLE/LOAD is ignored. Because it is a level, a request still held on return to IDLE re-enters LOAD on the next cycle.
- `in_valid` outside LOAD: no handshake and no effect.
- Reset, including mid-operation: state=IDLE and all counters=0. Every output is 0: `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `mat_loaded`, `out_data`, `out_valid`, `done`, `err`. The buffer contents become don't-care.

## Timing
- `host_req_mat` high at cycle T gives LOAD and `in_ready`=1 at T+1.
- An input handshake at cycle k gives `mem_we`=1 at k+1, for exactly one cycle per handshake.
- Back-to-back handshakes every cycle are supported: 8 bytes take 8 cycles.
- The 8th handshake at cycle k gives `mat_loaded`=1 at k+1, with state WAIT and `in_ready`=0 at k+1.
- The 4th `host_mat_wb` at cycle j gives `out_valid`=1 and byte 0 at j+1.
- The last output handshake at cycle m gives `done`=1 and IDLE at m+1, with `out_valid`=0 at m+1.
- Throughput: one output byte per cycle when `out_ready` is held high.

## Configuration
- `HOST_IF_SAT8_EN` defined:
  - Each result saturates to signed 8-bit at capture (>127 becomes 0x7F, <-128 becomes 0x80).
  - DRAIN sends 4 bytes, one per result.
- Undefined: DRAIN sends 8 bytes, LSB then MSB of each 16-bit result, with no saturation.

## Test plan
- Load: `host_req_mat`=1, then `in_data` 0x01..0x08 with `in_valid` every cycle -> `mem_we` writes addr 0..7 = 0x01..0x08 on consecutive cycles, `mat_loaded` pulses once, `in_ready` drops.
- Gapped input: `in_valid` toggled 1/0 for the 8 bytes -> still exactly 8 writes at the correct addresses; the abort case (drop `host_req_mat` after 3 bytes) -> IDLE, no `mat_loaded`, and the next load restarts at addr 0.
- Writeback, no macro: results 0x0123, 0xFFFE, 0x7FFF, 0x8000 -> out bytes 23 01 FE FF FF 7F 00 80, then `done` pulse.
- Backpressure: `out_ready` low for 3 cycles mid-drain -> `out_data` held constant, no byte lost or duplicated.
- With `HOST_IF_SAT8_EN`: the same results -> bytes 7F FE 7F 80; a `host_mat_wb` in IDLE -> `err`=1, remaining 1 through the next full transaction.
- Reset asserted mid-DRAIN -> all outputs 0 immediately; after release, a new load/writeback runs correctly.
